// File: rtl/bandai2003_pkg.sv
// Shared constants, result codes and FSM encoding for the Bandai 2003 unlock host.
package bandai2003_pkg;

    localparam logic [7:0]  ADDR_ACK     = 8'h5A;
    localparam logic [7:0]  ADDR_NAK     = 8'hA5;
    localparam logic [7:0]  ADDR_IDLE    = 8'hFF;
    localparam logic [15:0] UNLOCK_WORD  = 16'h28A0;
    localparam int          REPLY_BITS   = 18;              // start + 16 payload + stop
    localparam int          PAYLOAD_BITS = REPLY_BITS - 2;

    localparam logic [1:0]  ERR_NONE     = 2'b00;
    localparam logic [1:0]  ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0]  ERR_STOP     = 2'b10;
    localparam logic [1:0]  ERR_PAYLOAD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACK   = 3'd1,
        ST_NAK   = 3'd2,
        ST_HUNT  = 3'd3,
        ST_SHIFT = 3'd4,
        ST_STOP  = 3'd5,
        ST_FIN   = 3'd6
    } state_t;

    // Address-bus value presented while the FSM sits in a given state.
    function automatic logic [7:0] addr_for(state_t s);
        case (s)
            ST_ACK:  addr_for = ADDR_ACK;
            ST_NAK:  addr_for = ADDR_NAK;
            default: addr_for = ADDR_IDLE;
        endcase
    endfunction

    // The bus is driven from the first unlock address until the reply is checked.
    function automatic logic oe_for(state_t s);
        case (s)
            ST_ACK, ST_NAK, ST_HUNT, ST_SHIFT, ST_STOP: oe_for = 1'b1;
            default:                                    oe_for = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bandai_unlock_host_if.sv
// Host-side signal bundle: console control, cartridge bus, results and FSM debug state.
// Handshake: START is a one-cycle request honoured only while BUSY=0; every accepted
// START produces exactly one one-cycle DONE, with OK/ERR/WORD valid from that cycle
// and held until the next accepted START.
interface bandai_unlock_host_if;
    import bandai2003_pkg::*;

    logic        START;
    logic        SI;
    logic [7:0]  ADDR;
    logic        ADDR_OE;
    logic        BUSY;
    logic        DONE;
    logic        OK;
    logic [1:0]  ERR;
    logic [15:0] WORD;
    logic        SYS_CTRL1_B7;
    state_t      STATE;

    modport master (
        input  START, SI,
        output ADDR, ADDR_OE, BUSY, DONE, OK, ERR, WORD, SYS_CTRL1_B7, STATE
    );

    modport slave (
        output START, SI,
        input  ADDR, ADDR_OE, BUSY, DONE, OK, ERR, WORD, SYS_CTRL1_B7, STATE
    );

endinterface

// File: rtl/bandai_sideband_rx.sv
// Reply receiver datapath: start-bit hunt with timeout, 16-bit LSB-first shifter, stop check.
module bandai_sideband_rx
    import bandai2003_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,        // clears the counters before a hunt
    input  logic        hunt,       // FSM is waiting for the start bit
    input  logic        shift,      // FSM is collecting payload bits
    input  logic        si,
    output logic        start_seen,
    output logic        timeout,
    output logic        done,       // this cycle samples the last payload bit
    output logic        stop_ok,
    output logic [15:0] word
);

    localparam int             TW     = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]     B_LAST = 4'(PAYLOAD_BITS - 1);

    logic [TW-1:0] tcnt;
    logic [3:0]    bcnt;

    assign start_seen = hunt & ~si;
    assign timeout    = hunt & si & (tcnt == T_LAST);
    assign done       = shift & (bcnt == B_LAST);
    assign stop_ok    = ~si;

    // Saturating counters and the right-moving shifter (first bit ends in word[0]).
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
            bcnt <= '0;
            word <= '0;
        end else begin
            if (arm)
                tcnt <= '0;
            else if (hunt && tcnt != T_LAST)
                tcnt <= tcnt + TW'(1);

            if (arm || start_seen)
                bcnt <= '0;
            else if (shift && bcnt != B_LAST)
                bcnt <= bcnt + 4'd1;

            if (shift)
                word <= {si, word[15:1]};
        end
    end

endmodule

// File: rtl/bandai_unlock_host.sv
// Unlock host top: sequencing FSM, cartridge address driver and result/sticky registers.
module bandai_unlock_host
    import bandai2003_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 64,
    parameter logic [15:0] EXPECT_WORD = UNLOCK_WORD
) (
    input  logic                 CLK,
    input  logic                 RST,
    bandai_unlock_host_if.master bus
);

    state_t      state, state_next;
    logic        clr_res, set_ok, set_err;
    logic [1:0]  err_code;
    logic        start_seen, timeout, rx_done, stop_ok;
    logic [15:0] rx_word;

    bandai_sideband_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk        (CLK),
        .rst        (RST),
        .arm        (state == ST_NAK),
        .hunt       (state == ST_HUNT),
        .shift      (state == ST_SHIFT),
        .si         (bus.SI),
        .start_seen (start_seen),
        .timeout    (timeout),
        .done       (rx_done),
        .stop_ok    (stop_ok),
        .word       (rx_word)
    );

    assign bus.WORD  = rx_word;
    assign bus.STATE = state;

    // Next-state and result decisions; START is only looked at from IDLE.
    always_comb begin
        state_next = state;
        clr_res    = 1'b0;
        set_ok     = 1'b0;
        set_err    = 1'b0;
        err_code   = ERR_NONE;
        case (state)
            ST_IDLE: if (bus.START) begin
                state_next = ST_ACK;
                clr_res    = 1'b1;
            end
            ST_ACK:  state_next = ST_NAK;
            ST_NAK:  state_next = ST_HUNT;
            ST_HUNT: begin
                if (start_seen) begin
                    state_next = ST_SHIFT;
                end else if (timeout) begin
                    state_next = ST_FIN;
                    set_err    = 1'b1;
                    err_code   = ERR_TIMEOUT;
                end
            end
            ST_SHIFT: if (rx_done) state_next = ST_STOP;
            ST_STOP: begin
                state_next = ST_FIN;
                if (!stop_ok) begin
                    set_err  = 1'b1;
                    err_code = ERR_STOP;
                end else if (rx_word != EXPECT_WORD) begin
                    set_err  = 1'b1;
                    err_code = ERR_PAYLOAD;
                end else begin
                    set_ok = 1'b1;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State and registered outputs; bus outputs are decoded from the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state            <= ST_IDLE;
            bus.ADDR         <= ADDR_IDLE;
            bus.ADDR_OE      <= 1'b0;
            bus.BUSY         <= 1'b0;
            bus.DONE         <= 1'b0;
            bus.OK           <= 1'b0;
            bus.ERR          <= ERR_NONE;
            bus.SYS_CTRL1_B7 <= 1'b0;
        end else begin
            state       <= state_next;
            bus.ADDR    <= addr_for(state_next);
            bus.ADDR_OE <= oe_for(state_next);
            bus.BUSY    <= (state_next != ST_IDLE);
            bus.DONE    <= (state_next == ST_FIN);
            if (clr_res) begin
                bus.OK  <= 1'b0;
                bus.ERR <= ERR_NONE;
            end
            if (set_ok) begin
                bus.OK           <= 1'b1;
                bus.SYS_CTRL1_B7 <= 1'b1;
            end
            if (set_err)
                bus.ERR <= err_code;
        end
    end

endmodule
